npc_pc_unit: RTL and testbench

- Parametrised next-PC generator plus fetch PC register for the 5-stage MIPS pipeline.
- Replaces the purely combinational next-PC selector. Owns the F-stage PC, with stall hold and exception/ERET redirect.
- Adds a return-address stack (RAS) that cross-checks jr $ra targets, plus saturating branch performance counters.
- Branches and jumps resolve in D; the delay slot is always executed.

---
 rtl/npc_pc_unit_pkg.sv | 16 +
 rtl/npc_pc_unit_ras_stack.sv | 53 +++++
 rtl/npc_pc_unit.sv | 130 +++++++++++++
 tb/tb_npc_pc_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/npc_pc_unit_pkg.sv
// Shared next-PC opcodes and default vectors for the fetch PC unit.
// No logic here; constants only.
package npc_pc_unit_pkg;

  localparam logic [2:0] NPC_SEQ  = 3'd0;
  localparam logic [2:0] NPC_BEQ  = 3'd1;
  localparam logic [2:0] NPC_J    = 3'd2;
  localparam logic [2:0] NPC_JR   = 3'd3;
  localparam logic [2:0] NPC_BNE  = 3'd4;
  localparam logic [2:0] NPC_JAL  = 3'd5;
  localparam logic [2:0] NPC_JRRA = 3'd6;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;

endpackage

// File: rtl/npc_pc_unit_ras_stack.sv
// Circular return-address stack; push/pop take effect on the clock edge, top is combinational.
// A push when full overwrites the oldest entry; a pop when empty is ignored.
module ras_stack #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] top,
  output logic              nonempty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     ptr_inc;
  logic [PW-1:0]     ptr_dec;
  logic [CW-1:0]     cnt;

  // ptr is the next write slot, so the top entry sits one below it
  assign ptr_inc  = (DEPTH == 1) ? '0 : ptr + PW'(1);
  assign ptr_dec  = (DEPTH == 1) ? '0 : ptr - PW'(1);
  assign top      = mem[ptr_dec];
  assign nonempty = (cnt != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push) begin
      ptr <= ptr_inc;
      if (cnt != CNT_FULL) begin
        cnt <= cnt + CW'(1);
      end
    end else if (pop && nonempty) begin
      ptr <= ptr_dec;
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/npc_pc_unit.sv
// Fetch PC register with next-PC select, exception/ERET redirect, RAS cross-check and branch counters.
// npc is combinational, pc_f follows one cycle later; stall_f holds pc_f unless a redirect is pending.
import npc_pc_unit_pkg::*;

module npc_pc_unit #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEF_RESET_PC),
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(DEF_EXC_VEC),
  parameter int                RAS_DEPTH = 4,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_f,
  input  logic [2:0]        npc_op,
  input  logic [31:0]       instr_d,
  input  logic [ADDR_W-1:0] pc_d,
  input  logic [ADDR_W-1:0] ra_data,
  input  logic              zero,
  input  logic              exc_req,
  input  logic              eret_req,
  input  logic [ADDR_W-1:0] epc,
  output logic [ADDR_W-1:0] pc_f,
  output logic [ADDR_W-1:0] npc,
  output logic [ADDR_W-1:0] link_addr,
  output logic              ras_mismatch,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] boff;
  logic [ADDR_W-1:0] btgt;
  logic [ADDR_W-1:0] jtgt;
  logic              advance;
  logic              is_branch;
  logic              taken;
  logic              ras_push;
  logic              ras_pop;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_nonempty;
  logic              mismatch_next;
  logic              unused_ok;

  assign unused_ok = ^instr_d[31:26];

  assign seq_pc    = pc_f + ADDR_W'(4);
  assign boff      = {{(ADDR_W-18){instr_d[15]}}, instr_d[15:0], 2'b00};
  assign btgt      = pc_d + ADDR_W'(4) + boff;
  assign link_addr = pc_d + ADDR_W'(8);

  generate
    if (ADDR_W > 28) begin : g_jtgt_hi
      assign jtgt = {pc_f[ADDR_W-1:28], instr_d[25:0], 2'b00};
    end else begin : g_jtgt_28
      assign jtgt = {instr_d[25:0], 2'b00};
    end
  endgenerate

  always_comb begin
    npc = seq_pc;
    if (exc_req) begin
      npc = EXC_VEC;
    end else if (eret_req) begin
      npc = epc;
    end else if (stall_f) begin
      npc = pc_f;
    end else begin
      case (npc_op)
        NPC_BEQ:          npc = zero  ? btgt : seq_pc;
        NPC_BNE:          npc = !zero ? btgt : seq_pc;
        NPC_J, NPC_JAL:   npc = jtgt;
        NPC_JR, NPC_JRRA: npc = ra_data;
        default:          npc = seq_pc;
      endcase
    end
  end

  // Side effects (RAS, counters) only count once per instruction actually leaving D
  assign advance   = !exc_req && !eret_req && !stall_f;
  assign is_branch = (npc_op == NPC_BEQ) || (npc_op == NPC_BNE);
  assign taken     = ((npc_op == NPC_BEQ) && zero) || ((npc_op == NPC_BNE) && !zero);
  assign ras_push  = advance && (npc_op == NPC_JAL);
  assign ras_pop   = advance && (npc_op == NPC_JRRA);

  generate
    if (RAS_DEPTH > 0) begin : g_ras
      ras_stack #(
        .DEPTH (RAS_DEPTH),
        .ADDR_W(ADDR_W)
      ) u_ras (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (ras_push),
        .pop     (ras_pop),
        .din     (link_addr),
        .top     (ras_top),
        .nonempty(ras_nonempty)
      );
    end else begin : g_no_ras
      assign ras_top      = '0;
      assign ras_nonempty = 1'b0;
    end
  endgenerate

  assign mismatch_next = ras_pop && ras_nonempty && (ras_top != ra_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f         <= RESET_PC;
      ras_mismatch <= 1'b0;
      branch_cnt   <= '0;
      taken_cnt    <= '0;
    end else begin
      pc_f         <= npc;
      ras_mismatch <= mismatch_next;
      if (advance && is_branch) begin
        if (branch_cnt != CNT_MAX) begin
          branch_cnt <= branch_cnt + CNT_W'(1);
        end
        if (taken && (taken_cnt != CNT_MAX)) begin
          taken_cnt <= taken_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_npc_pc_unit.sv
// Directed plus randomized bench for npc_pc_unit against a queue-based reference model.
module tb_npc_pc_unit;

  localparam int CMAX = 3;  // CNT_W = 2

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall_f, zero, exc_req, eret_req;
  logic [2:0]  npc_op;
  logic [31:0] instr_d, pc_d, ra_data, epc;
  logic [31:0] pc_f, npc, link_addr;
  logic        ras_mismatch;
  logic [1:0]  branch_cnt, taken_cnt;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  int          m_bc, m_tc;
  logic        m_mm;

  npc_pc_unit #(.CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .npc_op(npc_op),
    .instr_d(instr_d), .pc_d(pc_d), .ra_data(ra_data), .zero(zero),
    .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
    .pc_f(pc_f), .npc(npc), .link_addr(link_addr),
    .ras_mismatch(ras_mismatch), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_npc();
    int          off;
    logic [31:0] btgt;
    off  = $signed(instr_d[15:0]) * 4;
    btgt = pc_d + 32'd4 + 32'(off);
    if (exc_req)  return 32'h0000_4180;
    if (eret_req) return epc;
    if (stall_f)  return m_pc;
    case (npc_op)
      3'd1:       return zero  ? btgt : m_pc + 32'd4;
      3'd4:       return !zero ? btgt : m_pc + 32'd4;
      3'd2, 3'd5: return {m_pc[31:28], instr_d[25:0], 2'b00};
      3'd3, 3'd6: return ra_data;
      default:    return m_pc + 32'd4;
    endcase
  endfunction

  task automatic drive(input logic [2:0] op, input logic z, input logic st, input logic ex,
                       input logic er, input logic [31:0] pd, input logic [31:0] ins,
                       input logic [31:0] ra);
    npc_op = op; zero = z; stall_f = st; exc_req = ex; eret_req = er;
    pc_d = pd; instr_d = ins; ra_data = ra;
  endtask

  task automatic cycle();
    logic [31:0] en;
    logic        mm;
    #1;
    en = model_npc();
    mm = 1'b0;
    chk("npc", npc, en);
    chk("link_addr", link_addr, pc_d + 32'd8);
    if (!exc_req && !eret_req && !stall_f) begin
      if (npc_op == 3'd5) begin
        m_ras.push_back(pc_d + 32'd8);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end
      if (npc_op == 3'd6 && m_ras.size() > 0) begin
        mm = (m_ras[$] != ra_data);
        void'(m_ras.pop_back());
      end
      if (npc_op == 3'd1 || npc_op == 3'd4) begin
        m_bc = (m_bc < CMAX) ? m_bc + 1 : CMAX;
        if ((npc_op == 3'd1) == zero) m_tc = (m_tc < CMAX) ? m_tc + 1 : CMAX;
      end
    end
    @(posedge clk);
    #1;
    m_pc = en;
    m_mm = mm;
    chk("pc_f", pc_f, m_pc);
    chk("ras_mismatch", {31'b0, ras_mismatch}, {31'b0, m_mm});
    chk("branch_cnt", {30'b0, branch_cnt}, 32'(m_bc));
    chk("taken_cnt", {30'b0, taken_cnt}, 32'(m_tc));
  endtask

  task automatic do_reset();
    drive(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    m_pc = 32'h0000_3000; m_ras.delete(); m_bc = 0; m_tc = 0; m_mm = 1'b0;
    chk("rst_pc_f", pc_f, 32'h0000_3000);
    chk("rst_mismatch", {31'b0, ras_mismatch}, 32'd0);
    chk("rst_branch_cnt", {30'b0, branch_cnt}, 32'd0);
    chk("rst_taken_cnt", {30'b0, taken_cnt}, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] a[5];
    logic [31:0] held;
    logic [2:0]  op;
    epc = 32'h0000_5000;
    drive(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    @(posedge clk);
    #1;

    // 1: reset then sequential fetch
    do_reset();
    cycle(); chk("t1_pc1", pc_f, 32'h0000_3004);
    cycle(); chk("t1_pc2", pc_f, 32'h0000_3008);
    cycle(); chk("t1_pc3", pc_f, 32'h0000_300C);

    // 2: beq taken backwards, then bne not taken
    drive(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3010, 32'h1000_FFFE, 32'h0);
    #1 chk("t2_beq_npc", npc, 32'h0000_300C);
    cycle();
    drive(3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3010, 32'h1400_FFFE, 32'h0);
    #1 chk("t2_bne_npc", npc, 32'h0000_3010);
    cycle();
    chk("t2_branch_cnt", {30'b0, branch_cnt}, 32'd2);
    chk("t2_taken_cnt", {30'b0, taken_cnt}, 32'd1);

    // 3: stall holds pc_f, exception overrides stall
    held = m_pc;
    drive(3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_3014, 32'h0800_0C40, 32'h0);
    cycle(); cycle();
    chk("t3_held", pc_f, held);
    drive(3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_3014, 32'h1000_0004, 32'h0);
    cycle();
    chk("t3_exc_pc", pc_f, 32'h0000_4180);
    chk("t3_branch_cnt", {30'b0, branch_cnt}, 32'd2);

    // 4: five pushes into a 4-deep RAS, five pops
    for (int i = 0; i < 5; i++) begin
      a[i] = 32'h0000_3100 + 32'(i * 16) + 32'd8;
      drive(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, a[i] - 32'd8, 32'h0C00_0100, 32'h0);
      cycle();
    end
    for (int i = 4; i >= 0; i--) begin
      drive(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3200, 32'h03E0_0008, a[i]);
      cycle();
      chk("t4_no_mismatch", {31'b0, ras_mismatch}, 32'd0);
    end

    // 5: mismatch pulse lasts one cycle
    drive(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3018, 32'h0C00_0200, 32'h0);
    cycle();
    drive(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3300, 32'h03E0_0008, 32'h0000_3024);
    #1 chk("t5_npc", npc, 32'h0000_3024);
    cycle();
    chk("t5_pulse", {31'b0, ras_mismatch}, 32'd1);
    drive(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    cycle();
    chk("t5_clear", {31'b0, ras_mismatch}, 32'd0);

    // 6: counter saturation at 2 bits
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, m_pc, 32'h1000_0003, 32'h0);
      cycle();
    end
    drive(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    cycle();
    chk("t6_branch_sat", {30'b0, branch_cnt}, 32'd3);
    chk("t6_taken_sat", {30'b0, taken_cnt}, 32'd3);

    // Randomized traffic, with a mid-run reset to exercise counters again
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      op = 3'($urandom_range(0, 7));
      drive(op, 1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 15) == 0), $urandom & 32'hFFFF_FFFC, $urandom,
            (m_ras.size() > 0 && $urandom_range(0, 1) == 1) ? m_ras[$] : ($urandom & 32'hFFFF_FFFC));
      epc = $urandom & 32'hFFFF_FFFC;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
